// File: rtl/mem_bank_atomics_adapter.sv
// -----------------------------------------------------------------------------
// mem_bank_atomics_adapter
//
// Sits behind one bank port of the interleaved AXI-to-memory converter. It
// takes that port's req/gnt memory stream and drives a single-port SRAM macro
// that has a fixed one-cycle read latency.
//
// Plain reads and writes go straight through to the SRAM in the cycle they are
// granted, and their response comes back one cycle later. AXI5 atomics
// (AtomicStore, AtomicLoad, AtomicSwap) are done as a read-modify-write on the
// SRAM, so the bank does not need a separate atomics unit:
//   grant + SRAM read  ->  ATOP_RD (capture old value, compute result)
//                      ->  ATOP_WR (write result, respond with old value)
// AtomicCompare is not supported. It is still granted and answered with the
// old value, but nothing is written, and atop_err_o pulses for one cycle.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   mem_req_i         request valid
//   mem_gnt_o         request accepted this cycle
//   mem_addr_i        byte address
//   mem_wdata_i       write data / atomic operand
//   mem_strb_i        byte enables
//   mem_atop_i        AXI5 ATOP encoding (bit 3, endianness, is ignored)
//   mem_we_i          write enable for plain accesses
//   mem_rvalid_o      response valid, exactly one per grant, in order
//   mem_rdata_o       read data, or the old value for atomics
//   sram_req_o        SRAM access enable
//   sram_we_o         SRAM write enable
//   sram_addr_o       SRAM word address
//   sram_wdata_o      SRAM write data
//   sram_be_o         SRAM byte enables
//   sram_rdata_i      SRAM read data, valid the cycle after a read
//   busy_o            an atomic is in flight or a response is pending
//   atop_err_o        one-cycle pulse for an unsupported ATOP
// -----------------------------------------------------------------------------
module mem_bank_atomics_adapter #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,  // 32 or 64
    parameter int unsigned SramAddrWidth = 10
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     mem_req_i,
    output logic                     mem_gnt_o,
    input  logic [AddrWidth-1:0]     mem_addr_i,
    input  logic [DataWidth-1:0]     mem_wdata_i,
    input  logic [DataWidth/8-1:0]   mem_strb_i,
    input  logic [5:0]               mem_atop_i,
    input  logic                     mem_we_i,
    output logic                     mem_rvalid_o,
    output logic [DataWidth-1:0]     mem_rdata_o,
    output logic                     sram_req_o,
    output logic                     sram_we_o,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic [DataWidth-1:0]     sram_wdata_o,
    output logic [DataWidth/8-1:0]   sram_be_o,
    input  logic [DataWidth-1:0]     sram_rdata_i,
    output logic                     busy_o,
    output logic                     atop_err_o
);

    localparam int unsigned StrbWidth  = DataWidth / 8;
    localparam int unsigned ByteOffset = $clog2(StrbWidth);

    typedef logic [AddrWidth-1:0] addr_t;
    typedef logic [DataWidth-1:0] data_t;
    typedef logic [StrbWidth-1:0] strb_t;

    // ATOP[5:4] selects the transaction class.
    localparam logic [1:0] AtopNone    = 2'b00;
    localparam logic [1:0] AtopStore   = 2'b01;
    localparam logic [1:0] AtopLoad    = 2'b10;
    localparam logic [1:0] AtopSwapCmp = 2'b11;

    // ATOP[2:0] selects the arithmetic operation for store and load.
    localparam logic [2:0] OpAdd  = 3'b000;
    localparam logic [2:0] OpClr  = 3'b001;
    localparam logic [2:0] OpEor  = 3'b010;
    localparam logic [2:0] OpSet  = 3'b011;
    localparam logic [2:0] OpSmax = 3'b100;
    localparam logic [2:0] OpSmin = 3'b101;
    localparam logic [2:0] OpUmax = 3'b110;
    localparam logic [2:0] OpUmin = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        ATOP_RD,
        ATOP_WR
    } state_t;

    state_t                   state_q;
    data_t                    op_q;
    strb_t                    strb_q;
    logic [5:0]               atop_q;
    logic [SramAddrWidth-1:0] addr_q;
    data_t                    old_q;
    data_t                    result_q;
    logic                     write_q;
    logic                     err_q;
    logic                     plain_rvalid_q;

    addr_t                    req_addr;
    logic [SramAddrWidth-1:0] req_word;
    logic                     is_atop;
    logic                     atop_arith;
    data_t                    atop_result;
    logic                     atop_supported;
    logic                     unused_bits;

    assign req_addr = mem_addr_i;
    assign req_word = req_addr[ByteOffset +: SramAddrWidth];
    assign is_atop  = (mem_atop_i[5:4] != AtopNone);

    // Address bits outside the word index and the endianness bit carry no
    // meaning for this bank.
    assign unused_bits = ^{req_addr, atop_q[3]};

    // Result of the latched atomic, computed from the SRAM data that arrives
    // during ATOP_RD. Every operation works on the full word; byte enables
    // only take effect when the result is written back.
    always_comb begin
        atop_result    = sram_rdata_i;
        atop_supported = 1'b0;
        case (atop_q[5:4])
            AtopStore, AtopLoad: begin
                atop_supported = 1'b1;
                case (atop_q[2:0])
                    OpAdd:  atop_result = sram_rdata_i + op_q;
                    OpClr:  atop_result = sram_rdata_i & ~op_q;
                    OpEor:  atop_result = sram_rdata_i ^ op_q;
                    OpSet:  atop_result = sram_rdata_i | op_q;
                    OpSmax: atop_result = ($signed(sram_rdata_i) > $signed(op_q)) ? sram_rdata_i : op_q;
                    OpSmin: atop_result = ($signed(sram_rdata_i) < $signed(op_q)) ? sram_rdata_i : op_q;
                    OpUmax: atop_result = (sram_rdata_i > op_q) ? sram_rdata_i : op_q;
                    OpUmin: atop_result = (sram_rdata_i < op_q) ? sram_rdata_i : op_q;
                    default: atop_result = sram_rdata_i;
                endcase
            end
            AtopSwapCmp: begin
                // Only swap is handled. Compare and the reserved encodings
                // fall through as read-only with an error pulse.
                if (atop_q[2:0] == 3'b000) begin
                    atop_supported = 1'b1;
                    atop_result    = op_q;
                end
            end
            default: begin
                atop_supported = 1'b0;
            end
        endcase
    end

    // Sequencer and response registers. A plain access only arms the one-cycle
    // response flag. An atomic latches its operands, spends one cycle waiting
    // for the SRAM read data, then one cycle writing back and responding.
    // Reset in the middle of an atomic drops both the write and the response.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            op_q           <= '0;
            strb_q         <= '0;
            atop_q         <= '0;
            addr_q         <= '0;
            old_q          <= '0;
            result_q       <= '0;
            write_q        <= 1'b0;
            err_q          <= 1'b0;
            plain_rvalid_q <= 1'b0;
        end else begin
            plain_rvalid_q <= 1'b0;
            err_q          <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (mem_req_i) begin
                        if (is_atop) begin
                            op_q    <= mem_wdata_i;
                            strb_q  <= mem_strb_i;
                            atop_q  <= mem_atop_i;
                            addr_q  <= req_word;
                            state_q <= ATOP_RD;
                        end else begin
                            plain_rvalid_q <= 1'b1;
                        end
                    end
                end
                ATOP_RD: begin
                    old_q    <= sram_rdata_i;
                    result_q <= atop_result;
                    write_q  <= atop_supported;
                    err_q    <= ~atop_supported;
                    state_q  <= ATOP_WR;
                end
                ATOP_WR: begin
                    write_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Request and SRAM side. In IDLE the request goes straight to the SRAM; an
    // atomic is issued as a read. While an atomic is in flight the stream is
    // stalled and the SRAM port belongs to the write-back. When there is no
    // access the SRAM signals are held at zero.
    always_comb begin
        mem_gnt_o    = 1'b0;
        sram_req_o   = 1'b0;
        sram_we_o    = 1'b0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_be_o    = '0;
        case (state_q)
            IDLE: begin
                if (mem_req_i) begin
                    mem_gnt_o    = 1'b1;
                    sram_req_o   = 1'b1;
                    sram_we_o    = mem_we_i & ~is_atop;
                    sram_addr_o  = req_word;
                    sram_wdata_o = mem_wdata_i;
                    sram_be_o    = mem_strb_i;
                end
            end
            ATOP_WR: begin
                if (write_q) begin
                    sram_req_o   = 1'b1;
                    sram_we_o    = 1'b1;
                    sram_addr_o  = addr_q;
                    sram_wdata_o = result_q;
                    sram_be_o    = strb_q;
                end
            end
            default: begin
            end
        endcase
    end

    // Response side. A plain response can never coincide with ATOP_WR, because
    // a grant in IDLE is always followed by either IDLE or ATOP_RD. That keeps
    // the responses in order without a queue.
    always_comb begin
        mem_rdata_o = '0;
        if (state_q == ATOP_WR) begin
            mem_rdata_o = old_q;
        end else if (plain_rvalid_q) begin
            mem_rdata_o = sram_rdata_i;
        end
    end

    assign mem_rvalid_o = plain_rvalid_q | (state_q == ATOP_WR);
    assign atop_err_o   = err_q;
    assign busy_o       = (state_q != IDLE) | plain_rvalid_q;

    // Upstream only issues ADD and the min/max operations on full words,
    // because a partial carry chain or compare would have no meaning.
    assign atop_arith = ((mem_atop_i[5:4] == AtopStore) || (mem_atop_i[5:4] == AtopLoad)) &&
                        ((mem_atop_i[2:0] == OpAdd) || mem_atop_i[2]);

    strb_full_for_arith : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (state_q == IDLE && mem_req_i && atop_arith) |-> (mem_strb_i == '1)
    );

    // A stalled request must be held unchanged until it is granted.
    req_stable_while_stalled : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (mem_req_i && !mem_gnt_o) |=>
            (mem_req_i && $stable(mem_addr_i) && $stable(mem_wdata_i) &&
             $stable(mem_strb_i) && $stable(mem_atop_i) && $stable(mem_we_i))
    );

endmodule

// File: tb/tb_mem_bank_atomics_adapter.sv
// -----------------------------------------------------------------------------
// tb_mem_bank_atomics_adapter
//
// Directed bench for mem_bank_atomics_adapter with the default 32-bit words and
// a 1024-word SRAM. A small behavioural SRAM with one-cycle read latency sits
// on the SRAM port. Inputs change on the falling edge or just after the rising
// edge. Outputs are sampled 1 time unit after either edge.
// -----------------------------------------------------------------------------
module tb_mem_bank_atomics_adapter;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_strb;
    logic [5:0]  mem_atop;
    logic        mem_we;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        sram_req;
    logic        sram_we;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata;
    logic [3:0]  sram_be;
    logic [31:0] sram_rdata;
    logic        busy;
    logic        atop_err;

    logic [31:0] sram_mem [0:1023];
    int          wr_count;
    int          check_count;
    int          pass_count;

    mem_bank_atomics_adapter #(
        .AddrWidth     (32),
        .DataWidth     (32),
        .SramAddrWidth (10)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .mem_req_i    (mem_req),
        .mem_gnt_o    (mem_gnt),
        .mem_addr_i   (mem_addr),
        .mem_wdata_i  (mem_wdata),
        .mem_strb_i   (mem_strb),
        .mem_atop_i   (mem_atop),
        .mem_we_i     (mem_we),
        .mem_rvalid_o (mem_rvalid),
        .mem_rdata_o  (mem_rdata),
        .sram_req_o   (sram_req),
        .sram_we_o    (sram_we),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_be_o    (sram_be),
        .sram_rdata_i (sram_rdata),
        .busy_o       (busy),
        .atop_err_o   (atop_err)
    );

    // 100 MHz-style clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port SRAM model: byte-enabled writes, reads land one cycle later.
    always @(posedge clk) begin
        if (sram_req) begin
            if (sram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (sram_be[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
                end
                wr_count <= wr_count + 1;
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    // Keeps the run bounded even if the sequencing goes badly wrong.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    task automatic applyStimulus(input logic req, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] strb, input logic [5:0] atop, input logic we);
        mem_req   = req;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_strb  = strb;
        mem_atop  = atop;
        mem_we    = we;
    endtask

    // One plain access: expects an immediate grant with pass-through SRAM
    // signals and a response in the following cycle.
    task automatic plainAccess(input string tag, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] strb, input logic [31:0] exp_rdata);
        logic [9:0] word;
        word = addr[11:2];
        @(negedge clk);
        applyStimulus(1'b1, addr, wdata, strb, 6'b000000, we);
        #1;
        checkOutput({tag, "_gnt"}, mem_gnt, 1'b1);
        checkOutput({tag, "_sram"}, {sram_req, sram_we, sram_addr, sram_be}, {1'b1, we, word, strb});
        @(posedge clk);
        #1;
        checkOutput({tag, "_rvalid"}, mem_rvalid, 1'b1);
        if (!we) checkOutput({tag, "_rdata"}, mem_rdata, exp_rdata);
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 6'h0, 1'b0);
    endtask

    // Issue one atomic, then keep a read of the same address pending during the
    // stall. Checks the two stall cycles, the old-value response, the write-back
    // (or its absence), and the value the read returns afterwards.
    task automatic atomicThenRead(input string tag, input logic [31:0] addr, input logic [31:0] op,
                                  input logic [3:0] strb, input logic [5:0] atop,
                                  input logic [31:0] exp_old, input logic [31:0] exp_new, input logic exp_err);
        int wr_before;
        @(negedge clk);
        applyStimulus(1'b1, addr, op, strb, atop, 1'b0);
        #1;
        checkOutput({tag, "_gnt"}, mem_gnt, 1'b1);
        checkOutput({tag, "_rd_issue"}, {sram_req, sram_we}, 2'b10);
        @(posedge clk);
        #1;
        wr_before = wr_count;
        applyStimulus(1'b1, addr, 32'h0, 4'hF, 6'b000000, 1'b0);
        #1;
        checkOutput({tag, "_stall1"}, {mem_gnt, sram_req, mem_rvalid, busy, atop_err}, 5'b00010);
        @(posedge clk);
        #1;
        checkOutput({tag, "_stall2_gnt"}, mem_gnt, 1'b0);
        checkOutput({tag, "_rvalid"}, mem_rvalid, 1'b1);
        checkOutput({tag, "_old"}, mem_rdata, exp_old);
        checkOutput({tag, "_err"}, atop_err, exp_err);
        checkOutput({tag, "_wr_en"}, sram_req, !exp_err);
        @(posedge clk);
        #1;
        checkOutput({tag, "_wr_count"}, wr_count - wr_before, exp_err ? 0 : 1);
        checkOutput({tag, "_after"}, {mem_gnt, mem_rvalid, atop_err}, 3'b100);
        @(posedge clk);
        #1;
        checkOutput({tag, "_new"}, {mem_rvalid, mem_rdata}, {1'b1, exp_new});
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 6'h0, 1'b0);
    endtask

    initial begin
        logic [31:0] burst_addr [3];
        logic [31:0] burst_data [3];
        int          wr_before;

        check_count = 0;
        pass_count  = 0;
        wr_count    = 0;
        sram_rdata  = 32'h0;
        rst         = 1'b1;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 6'h0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ctrl", {mem_gnt, mem_rvalid, sram_req, sram_we, busy, atop_err}, 6'b000000);
        checkOutput("reset_rdata", mem_rdata, 32'h0);
        checkOutput("reset_sram", {sram_addr, sram_wdata, sram_be}, 46'h0);
        @(negedge clk);
        rst = 1'b0;

        // Plain write then read
        plainAccess("wr40", 1'b1, 32'h40, 32'hDEADBEEF, 4'hF, 32'h0);
        plainAccess("rd40", 1'b0, 32'h40, 32'h0, 4'hF, 32'hDEADBEEF);

        // Back-to-back reads: one grant and one response every cycle
        plainAccess("wr44", 1'b1, 32'h44, 32'h11111111, 4'hF, 32'h0);
        plainAccess("wr48", 1'b1, 32'h48, 32'h22222222, 4'hF, 32'h0);
        burst_addr[0] = 32'h40; burst_data[0] = 32'hDEADBEEF;
        burst_addr[1] = 32'h44; burst_data[1] = 32'h11111111;
        burst_addr[2] = 32'h48; burst_data[2] = 32'h22222222;
        @(negedge clk);
        applyStimulus(1'b1, burst_addr[0], 32'h0, 4'hF, 6'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("burst_gnt", mem_gnt, 1'b1);
            @(posedge clk);
            #1;
            checkOutput("burst_rsp", {mem_rvalid, mem_rdata}, {1'b1, burst_data[i]});
            if (i < 2) applyStimulus(1'b1, burst_addr[i+1], 32'h0, 4'hF, 6'h0, 1'b0);
            else       applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 6'h0, 1'b0);
        end

        // AtomicLoad ADD: 5 + 3
        plainAccess("wr10", 1'b1, 32'h10, 32'd5, 4'hF, 32'h0);
        atomicThenRead("add", 32'h10, 32'd3, 4'hF, 6'b100000, 32'd5, 32'd8, 1'b0);

        // Signed versus unsigned max on the same starting value
        plainAccess("wr20a", 1'b1, 32'h20, 32'hFFFFFFFE, 4'hF, 32'h0);
        atomicThenRead("smax", 32'h20, 32'd1, 4'hF, 6'b100100, 32'hFFFFFFFE, 32'h00000001, 1'b0);
        plainAccess("wr20b", 1'b1, 32'h20, 32'hFFFFFFFE, 4'hF, 32'h0);
        atomicThenRead("umax", 32'h20, 32'd1, 4'hF, 6'b100110, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0);

        // Swap, then an unsupported compare
        plainAccess("wr30", 1'b1, 32'h30, 32'h000000FF, 4'hF, 32'h0);
        atomicThenRead("swap", 32'h30, 32'h00001234, 4'hF, 6'b110000, 32'h000000FF, 32'h00001234, 1'b0);
        atomicThenRead("cmp", 32'h30, 32'h00005555, 4'hF, 6'b110001, 32'h00001234, 32'h00001234, 1'b1);

        // Bitwise ops with partial strobes, and the remaining min/set variants
        plainAccess("wr60", 1'b1, 32'h60, 32'hFFFFFFFF, 4'hF, 32'h0);
        atomicThenRead("clr", 32'h60, 32'h0F0F0F0F, 4'b0011, 6'b010001, 32'hFFFFFFFF, 32'hFFFFF0F0, 1'b0);
        atomicThenRead("eor", 32'h60, 32'h000000FF, 4'hF, 6'b010010, 32'hFFFFF0F0, 32'hFFFFF00F, 1'b0);
        atomicThenRead("smin_neg", 32'h60, 32'd5, 4'hF, 6'b100101, 32'hFFFFF00F, 32'hFFFFF00F, 1'b0);
        atomicThenRead("umin", 32'h60, 32'd5, 4'hF, 6'b100111, 32'hFFFFF00F, 32'h00000005, 1'b0);
        atomicThenRead("set", 32'h60, 32'h00000030, 4'hF, 6'b010011, 32'h00000005, 32'h00000035, 1'b0);
        atomicThenRead("smin_min", 32'h60, 32'h80000000, 4'hF, 6'b100101, 32'h00000035, 32'h80000000, 1'b0);

        // In-order responses: plain read at t, atomic ADD at t+1 (wraps to 1)
        plainAccess("wr50", 1'b1, 32'h50, 32'hFFFFFFFF, 4'hF, 32'h0);
        plainAccess("wr54", 1'b1, 32'h54, 32'hAAAA5555, 4'hF, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h54, 32'h0, 4'hF, 6'b000000, 1'b0);
        #1;
        checkOutput("order_rd_gnt", mem_gnt, 1'b1);
        @(posedge clk);
        #1;
        checkOutput("order_first", {mem_rvalid, mem_rdata}, {1'b1, 32'hAAAA5555});
        applyStimulus(1'b1, 32'h50, 32'd2, 4'hF, 6'b100000, 1'b0);
        #1;
        checkOutput("order_at_gnt", mem_gnt, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 6'h0, 1'b0);
        checkOutput("order_gap", mem_rvalid, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("order_second", {mem_rvalid, mem_rdata}, {1'b1, 32'hFFFFFFFF});
        @(posedge clk);
        plainAccess("wrap_rd", 1'b0, 32'h50, 32'h0, 4'hF, 32'h00000001);

        // Reset while in ATOP_RD: nothing written, everything back to zero
        plainAccess("wr70", 1'b1, 32'h70, 32'h00000077, 4'hF, 32'h0);
        @(negedge clk);
        applyStimulus(1'b1, 32'h70, 32'h00000099, 4'hF, 6'b110000, 1'b0);
        #1;
        checkOutput("rstmid_gnt", mem_gnt, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 32'h0, 32'h0, 4'h0, 6'h0, 1'b0);
        wr_before = wr_count;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstmid_ctrl", {mem_gnt, mem_rvalid, sram_req, sram_we, busy, atop_err}, 6'b000000);
        checkOutput("rstmid_rdata", mem_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstmid_no_write", wr_count - wr_before, 0);
        plainAccess("rstmid_rd", 1'b0, 32'h70, 32'h0, 4'hF, 32'h00000077);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/mem_bank_atomics_adapter.md
Name: mem_bank_atomics_adapter

Overview:
- Per-bank shim directly downstream of one bank port of the interleaved AXI-to-memory converter.
- Accepts that port's req/gnt memory stream and drives a single-port SRAM macro with fixed 1-cycle read latency.
- Plain reads and writes pass through in one cycle.
- AXI5 ATOPs (AtomicStore, AtomicLoad, AtomicSwap) execute as an SRAM read-modify-write, so no separate atomics unit is needed.

Parameters:
- AddrWidth, 32, width of the byte address on the memory stream.
- DataWidth, 32, bank word width in bits; must be 32 or 64.
- SramAddrWidth, 10, word-address width of the SRAM macro.
- addr_t, logic[AddrWidth-1:0], dependent; do not override.
- data_t, logic[DataWidth-1:0], dependent; do not override.
- strb_t, logic[DataWidth/8-1:0], dependent; do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- mem_req_i  in  1  request valid.
- mem_gnt_o  out  1  request accepted this cycle.
- mem_addr_i  in  AddrWidth  byte address.
- mem_wdata_i  in  DataWidth  write data / atomic operand.
- mem_strb_i  in  DataWidth/8  byte enables.
- mem_atop_i  in  6  axi_pkg::atop_t.
- mem_we_i  in  1  write enable.
- mem_rvalid_o  out  1  response valid; exactly one per grant.
- mem_rdata_o  out  DataWidth  read data, or old value for atomics.
- sram_req_o  out  1  SRAM access enable.
- sram_we_o  out  1  SRAM write enable.
- sram_addr_o  out  SramAddrWidth  word address = mem_addr_i[log2(DataWidth/8) +: SramAddrWidth].
- sram_wdata_o  out  DataWidth  SRAM write data.
- sram_be_o  out  DataWidth/8  SRAM byte enables.
- sram_rdata_i  in  DataWidth  SRAM read data, valid the cycle after a read.
- busy_o  out  1  FSM not IDLE, or a response is pending.
- atop_err_o  out  1  one-cycle pulse on an unsupported ATOP.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; operand and old-value registers 0.
- FSM states: IDLE, ATOP_RD, ATOP_WR.
- IDLE, mem_atop_i[5:4]==00:
  - mem_gnt_o = mem_req_i (combinational).
  - SRAM signals pass through the same cycle: sram_we_o=mem_we_i, sram_be_o=mem_strb_i.
  - mem_rvalid_o registered 1 cycle after grant; mem_rdata_o = sram_rdata_i (undefined for writes).
  - Back-to-back grants sustain 1 access/cycle.
- IDLE, req with atop[5:4]!=00:
  - Grant; issue SRAM read of the address.
  - Latch wdata, strb, atop and word address; go to ATOP_RD.
- ATOP_RD:
  - mem_gnt_o=0, sram_req_o=0.
  - Capture sram_rdata_i as old value; compute result; go to ATOP_WR.
- ATOP_WR:
  - mem_gnt_o=0.
  - Write result to the latched address with the latched strb.
  - Assert mem_rvalid_o with mem_rdata_o = old value; return to IDLE.
  - Atomic response latency is 2 cycles after grant.
  - Next grant possible in the cycle after ATOP_WR, giving 3-cycle occupancy.
- Result by atop[2:0] for AtomicStore (01) and AtomicLoad (10):
  - ADD = old+op, modulo 2^DataWidth.
  - CLR = old & ~op; EOR = old ^ op; SET = old | op.
  - SMAX/SMIN: signed compare on the full word.
  - UMAX/UMIN: unsigned compare on the full word.
- Swap: atop == 6'b110000; result = op.
- Compare: atop == 6'b110001 is unsupported:
  - Read only, no write (sram_req_o=0 in ATOP_WR).
  - Return old value; pulse atop_err_o in the ATOP_WR cycle.
- Operand width rules:
  - Atomics operate on the full word.
  - Upstream guarantees full-word strb for SMAX/SMIN/UMAX/UMIN/ADD; a simulation assertion flags violations.
  - Bitwise ops honour any strb.
- atop[3] (endianness) is ignored; little-endian only.
- Response ordering is strictly in order: a plain access granted the cycle before an atomic responds first.
- A normal request presented during ATOP_RD/ATOP_WR stalls (gnt=0). Its request signals must remain stable per the req/gnt contract.
- Reset mid-atomic: FSM returns to IDLE; the pending write and rvalid are dropped. The SRAM keeps its pre-atomic value.
- busy_o = (state!=IDLE) | rvalid pending register.

Test Plan:
- Write 0xDEADBEEF to addr 0x40, strb 0xF, then read 0x40 → rvalid 1 cycle after each grant; read returns 0xDEADBEEF; continuous req yields a grant every cycle.
- Mem holds 5 at 0x10; AtomicLoad ADD op 3 → rvalid 2 cycles after grant, rdata 5; subsequent read returns 8; gnt low for 2 cycles.
- Mem 0xFFFFFFFE; AtomicLoad SMAX op 1 → stored 1. Same start, UMAX op 1 → stored 0xFFFFFFFE. Both return 0xFFFFFFFE.
- Mem 0x0000_00FF; AtomicSwap op 0x1234 → rdata 0xFF, mem 0x1234. AtomicCompare → atop_err_o pulses once, no SRAM write, rdata = old.
- Plain read granted at t, atomic issued t+1 → rvalids at t+1 (read data) and t+3 (old value), in order. ADD 0xFFFFFFFF+2 wraps to 1.
- Assert rst_i in ATOP_RD → all outputs 0 next cycle, no SRAM write, busy_o=0, mem value unchanged.
